// File: rtl/z80_bus_arbiter_if.sv
// rtl/z80_bus_arbiter_if.sv - requester and external bus signal bundle for z80_bus_arbiter
interface z80_bus_arbiter_if;
    // Instruction fetch port (memory read only)
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic [7:0]  f_rdata;

    // Data port (memory or IO, read or write)
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_we;
    logic        d_io;
    logic [7:0]  d_wdata;
    logic        d_ack;
    logic [7:0]  d_rdata;

    // External Z80-style bus, strobes active-high
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_mreq;
    logic        bus_iorq;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_wait;

    // Status
    logic        busy;
    logic        grant_d;

    // Arbiter side
    modport slave (
        input  f_req, f_addr,
        output f_ack, f_rdata,
        input  d_req, d_addr, d_we, d_io, d_wdata,
        output d_ack, d_rdata,
        output bus_addr, bus_wdata, bus_mreq, bus_iorq, bus_rd, bus_wr,
        input  bus_rdata, bus_wait,
        output busy, grant_d
    );

    // Requester / bus-device side
    modport master (
        output f_req, f_addr,
        input  f_ack, f_rdata,
        output d_req, d_addr, d_we, d_io, d_wdata,
        input  d_ack, d_rdata,
        input  bus_addr, bus_wdata, bus_mreq, bus_iorq, bus_rd, bus_wr,
        output bus_rdata, bus_wait,
        input  busy, grant_d
    );
endinterface

// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - two-requester Z80-style bus arbiter with T1/T2/T3 cycle FSM
module z80_bus_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic             clk,
    input  logic             rst,
    z80_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] WAIT_INIT  = 3'(WAIT_STATES);

    state_t     state;
    logic [3:0] starve_cnt;
    logic [2:0] wait_cnt;
    logic       pick_data;

    // Data wins a tie unless fetch has already been passed over STARVE_MAX times in a row.
    always_comb begin
        pick_data = 1'b0;
        if (bus.d_req && (!bus.f_req || (starve_cnt != STARVE_LIM))) begin
            pick_data = 1'b1;
        end
    end

    // Bus-cycle sequencer; all outputs are registered so strobes change only on clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            starve_cnt    <= '0;
            wait_cnt      <= '0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_mreq  <= 1'b0;
            bus.bus_iorq  <= 1'b0;
            bus.bus_rd    <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.f_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.f_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.busy      <= 1'b0;
            bus.grant_d   <= 1'b0;
        end else begin
            // Acks are single-cycle pulses raised only on the T2->T3 edge.
            bus.f_ack <= 1'b0;
            bus.d_ack <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A fetch that is not waiting cannot be starved, so history is dropped.
                    if (!bus.f_req) begin
                        starve_cnt <= '0;
                    end
                    if (bus.d_req || bus.f_req) begin
                        state       <= S_T1;
                        bus.busy    <= 1'b1;
                        bus.grant_d <= pick_data;
                        if (pick_data) begin
                            bus.bus_addr <= bus.d_addr;
                            if (bus.d_we) begin
                                bus.bus_wdata <= bus.d_wdata;
                            end
                            bus.bus_mreq <= ~bus.d_io;
                            bus.bus_iorq <= bus.d_io;
                            bus.bus_rd   <= ~bus.d_we;
                            bus.bus_wr   <= bus.d_we;
                            if (bus.f_req && (starve_cnt != STARVE_LIM)) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end else begin
                            // Fetch is always a memory read whatever the data-port controls say.
                            bus.bus_addr <= bus.f_addr;
                            bus.bus_mreq <= 1'b1;
                            bus.bus_iorq <= 1'b0;
                            bus.bus_rd   <= 1'b1;
                            bus.bus_wr   <= 1'b0;
                            starve_cnt   <= '0;
                        end
                    end
                end

                S_T1: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= S_T2;
                end

                S_T2: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (!bus.bus_wait) begin
                        state        <= S_T3;
                        bus.bus_mreq <= 1'b0;
                        bus.bus_iorq <= 1'b0;
                        bus.bus_rd   <= 1'b0;
                        bus.bus_wr   <= 1'b0;
                        // Read data is captured while RD is still asserted on the bus.
                        if (bus.bus_rd) begin
                            if (bus.grant_d) begin
                                bus.d_rdata <= bus.bus_rdata;
                            end else begin
                                bus.f_rdata <= bus.bus_rdata;
                            end
                        end
                        if (bus.grant_d) begin
                            bus.d_ack <= 1'b1;
                        end else begin
                            bus.f_ack <= 1'b1;
                        end
                    end
                end

                S_T3: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
